rr_display_arbiter: RTL and testbench

Round-robin scheduler that shares the single seven-segment digit (seg0) and the 3-bit index output among eight switch-driven requesters on the NVBoard top level. Each cycle it picks one active requester fairly, holds a one-hot grant while the requester keeps asking, and drives the granted index and its digit pattern. It replaces the free-running priority-encoder path, in which the highest set bit always wins, with a fair, registered, handshaked sequence.

---
 rtl/rr_display_arbiter_if.sv | 18 +
 rtl/rr_display_arbiter.sv | 159 +++++++++++++++
 tb/tb_rr_display_arbiter.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/rr_display_arbiter_if.sv
// Bundle of request, enable, grant and display signals for rr_display_arbiter.
// The master side drives req/en; the slave side (the arbiter) drives everything else.
interface rr_display_arbiter_if;
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SEG_W = 8;

  logic             en;
  logic [N_REQ-1:0] req;
  logic [N_REQ-1:0] grant;
  logic [IDX_W-1:0] gnt_idx;
  logic             gnt_valid;
  logic             flag;
  logic [SEG_W-1:0] seg0;

  modport master (output en, req, input grant, gnt_idx, gnt_valid, flag, seg0);
  modport slave  (input en, req, output grant, gnt_idx, gnt_valid, flag, seg0);
endinterface

// File: rtl/rr_display_arbiter.sv
// Round-robin arbiter sharing one seven-segment digit among eight requesters.
// Optional macro DWELL_TIMEOUT_EN: force release after DWELL granted cycles.
module rr_display_arbiter #(
  parameter int unsigned DWELL = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  rr_display_arbiter_if.slave  bus
);
  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned SEG_W = 8;
  localparam int unsigned CNT_W = 8;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_GRANT = 2'd1;
  localparam logic [1:0] S_GAP   = 2'd2;

  localparam logic [SEG_W-1:0] SEG_IDLE = 8'hFF;

  if (DWELL < 1 || DWELL > 255) begin : g_dwell_range
    $error("rr_display_arbiter: DWELL must be in 1..255");
  end

  logic [1:0]       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [N_REQ-1:0] grant_q, grant_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             flag_q, flag_d;
  logic [SEG_W-1:0] seg0_q, seg0_d;

  logic             win_found_c;
  logic [IDX_W-1:0] win_idx_c;
  logic [IDX_W-1:0] cand_c;
  logic             timeout_c;
  logic             release_c;

  // Active-low digit patterns, bit7..bit0 = a,b,c,d,e,f,g,dp.
  function automatic logic [SEG_W-1:0] seg_of(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    seg_of = 8'b0000_0010;
      3'd1:    seg_of = 8'b1001_1111;
      3'd2:    seg_of = 8'b0010_0101;
      3'd3:    seg_of = 8'b0000_1101;
      3'd4:    seg_of = 8'b1001_1001;
      3'd5:    seg_of = 8'b0100_1001;
      3'd6:    seg_of = 8'b0100_0001;
      default: seg_of = 8'b0001_1111;
    endcase
  endfunction

  // Search starts just after the last grant so the previous winner comes last.
  always_comb begin
    win_found_c = 1'b0;
    win_idx_c   = '0;
    cand_c      = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand_c = ptr_q + IDX_W'(k);
      if (!win_found_c && bus.req[cand_c]) begin
        win_found_c = 1'b1;
        win_idx_c   = cand_c;
      end
    end
  end

`ifdef DWELL_TIMEOUT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;
  assign timeout_c = (cnt_q == CNT_W'(DWELL - 1));
`else
  assign timeout_c = 1'b0;
`endif

  assign release_c = !bus.req[gnt_idx_q] || !bus.en || timeout_c;

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    grant_d     = grant_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    seg0_d      = seg0_q;
    flag_d      = |bus.req;
`ifdef DWELL_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (bus.en && win_found_c) begin
          state_d     = S_GRANT;
          ptr_d       = win_idx_c;
          grant_d     = N_REQ'(1) << win_idx_c;
          gnt_idx_d   = win_idx_c;
          gnt_valid_d = 1'b1;
          seg0_d      = seg_of(win_idx_c);
`ifdef DWELL_TIMEOUT_EN
          cnt_d       = '0;
`endif
        end
      end
      S_GRANT: begin
        if (release_c) begin
          state_d     = S_GAP;
          grant_d     = '0;
          gnt_idx_d   = '0;
          gnt_valid_d = 1'b0;
          seg0_d      = SEG_IDLE;
        end
`ifdef DWELL_TIMEOUT_EN
        else if (cnt_q != '1) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
`endif
      end
      S_GAP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d     = S_IDLE;
        grant_d     = '0;
        gnt_idx_d   = '0;
        gnt_valid_d = 1'b0;
        seg0_d      = SEG_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      ptr_q       <= 3'd7;
      grant_q     <= '0;
      gnt_idx_q   <= '0;
      gnt_valid_q <= 1'b0;
      flag_q      <= 1'b0;
      seg0_q      <= SEG_IDLE;
`ifdef DWELL_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      grant_q     <= grant_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      flag_q      <= flag_d;
      seg0_q      <= seg0_d;
`ifdef DWELL_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.grant     = grant_q;
  assign bus.gnt_idx   = gnt_idx_q;
  assign bus.gnt_valid = gnt_valid_q;
  assign bus.flag      = flag_q;
  assign bus.seg0      = seg0_q;
endmodule

// File: tb/tb_rr_display_arbiter.sv
// Scoreboard bench for rr_display_arbiter: a behavioural model predicts each edge,
// expected outputs are queued at drive time and compared after the edge.
module tb_rr_display_arbiter;
  localparam int unsigned TB_DWELL = 2;

  typedef struct packed {
    logic [7:0] grant;
    logic [2:0] idx;
    logic       valid;
    logic       flag;
    logic [7:0] seg;
  } exp_t;

  logic clk;
  logic rst;
  rr_display_arbiter_if bus_if ();

  rr_display_arbiter #(.DWELL(TB_DWELL)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned total = 0;
  int unsigned bad   = 0;
  exp_t        sb_q[$];

  logic [7:0] seg_tab [8] = '{8'b0000_0010, 8'b1001_1111, 8'b0010_0101, 8'b0000_1101,
                              8'b1001_1001, 8'b0100_1001, 8'b0100_0001, 8'b0001_1111};

  // Model state: 0 idle, 1 grant, 2 gap.
  int   m_state = 0;
  int   m_ptr   = 7;
  int   m_cnt   = 0;
  int   m_idx   = 0;
  bit   m_valid = 1'b0;
  bit   m_flag  = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_edge();
    exp_t e;
    bit   rel;
    if (!rst) begin
      m_state = 0; m_ptr = 7; m_cnt = 0; m_idx = 0; m_valid = 1'b0; m_flag = 1'b0;
    end else begin
      m_flag = (bus_if.req != 8'h00);
      case (m_state)
        0: if (bus_if.en && bus_if.req != 8'h00) begin
             for (int k = 1; k <= 8; k++) begin
               if (bus_if.req[(m_ptr + k) % 8]) begin
                 m_idx = (m_ptr + k) % 8;
                 break;
               end
             end
             m_ptr = m_idx; m_cnt = 0; m_valid = 1'b1; m_state = 1;
           end
        1: begin
             rel = !bus_if.req[m_idx] || !bus_if.en;
`ifdef DWELL_TIMEOUT_EN
             rel = rel || (m_cnt == int'(TB_DWELL) - 1);
`endif
             if (rel) begin
               m_valid = 1'b0; m_idx = 0; m_state = 2;
             end else if (m_cnt < 255) begin
               m_cnt++;
             end
           end
        default: m_state = 0;
      endcase
    end
    e.grant = m_valid ? (8'h01 << m_idx) : 8'h00;
    e.idx   = 3'(m_idx);
    e.valid = m_valid;
    e.flag  = m_flag;
    e.seg   = m_valid ? seg_tab[m_idx] : 8'hFF;
    sb_q.push_back(e);
  endtask

  // One clock: predict with the current inputs, let the edge happen, compare.
  task automatic step();
    exp_t e;
    model_edge();
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check_eq("grant", 32'(bus_if.grant), 32'(e.grant));
    check_eq("gnt_idx", 32'(bus_if.gnt_idx), 32'(e.idx));
    check_eq("gnt_valid", 32'(bus_if.gnt_valid), 32'(e.valid));
    check_eq("flag", 32'(bus_if.flag), 32'(e.flag));
    check_eq("seg0", 32'(bus_if.seg0), 32'(e.seg));
  endtask

  initial begin
    rst        = 1'b0;
    bus_if.en  = 1'b1;
    bus_if.req = 8'hFF;
    #1;
    // Reset held with everything requesting.
    repeat (2) step();
    check_eq("rst_grant", 32'(bus_if.grant), 32'h00);
    check_eq("rst_seg0", 32'(bus_if.seg0), 32'hFF);
    check_eq("rst_valid", 32'(bus_if.gnt_valid), 32'h0);
    check_eq("rst_flag", 32'(bus_if.flag), 32'h0);

    rst = 1'b1;
    step();
    check_eq("first_grant", 32'(bus_if.grant), 32'h01);
    check_eq("first_idx", 32'(bus_if.gnt_idx), 32'h0);
    check_eq("first_seg0", 32'(bus_if.seg0), 32'h02);

    // Switch to a single requester at index 4 and hold it.
    bus_if.req = 8'h10;
    repeat (3) step();
`ifndef DWELL_TIMEOUT_EN
    check_eq("hold_grant", 32'(bus_if.grant), 32'h10);
    for (int i = 0; i < 20; i++) step();
    check_eq("hold_grant_end", 32'(bus_if.grant), 32'h10);
    check_eq("hold_idx_end", 32'(bus_if.gnt_idx), 32'h4);
    check_eq("hold_seg0_end", 32'(bus_if.seg0), 32'h99);
    bus_if.req = 8'h00;
    step();
    check_eq("drop_grant", 32'(bus_if.grant), 32'h00);
    step();
`else
    for (int i = 0; i < 20; i++) step();
    bus_if.req = 8'h00;
    repeat (3) step();
`endif

    // Enable drop while index 2 is granted.
    bus_if.req = 8'h04;
    repeat (2) step();
    check_eq("en_pre_grant", 32'(bus_if.grant), 32'h04);
    bus_if.en = 1'b0;
    step();
    check_eq("en_drop_grant", 32'(bus_if.grant), 32'h00);
    bus_if.en = 1'b1;
    repeat (2) step();
    check_eq("en_regrant", 32'(bus_if.grant), 32'h04);

    // Mid-grant reset while index 5 is granted.
    bus_if.req = 8'h20;
    repeat (3) step();
    check_eq("mid_pre_grant", 32'(bus_if.grant), 32'h20);
    bus_if.req = 8'h21;
    rst = 1'b0;
    step();
    check_eq("mid_rst_grant", 32'(bus_if.grant), 32'h00);
    check_eq("mid_rst_seg0", 32'(bus_if.seg0), 32'hFF);
    rst = 1'b1;
    step();
    check_eq("mid_rst_next", 32'(bus_if.grant), 32'h01);

    // Wrap and fairness patterns held long enough to cycle through requesters.
    bus_if.req = 8'h81;
    for (int i = 0; i < 30; i++) step();
    bus_if.req = 8'hFF;
    for (int i = 0; i < 40; i++) step();
    bus_if.req = 8'h00;
    repeat (3) step();

    // Random traffic with occasional enable drops and reset pulses.
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) bus_if.req = 8'($urandom_range(0, 255));
      bus_if.en = ($urandom_range(0, 15) != 0);
      rst       = ($urandom_range(0, 63) != 0);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
